rf_writer: RTL

Write-side front end for the pipelined core's register file. It merges two result sources into the register file's single write port: the in-order pipeline writeback, which never stalls, and a multi-cycle load unit, whose results are buffered in a small FIFO. It also reports to decode which registers have writes still in flight, so hazard logic can stall or bypass.

---
 rtl/rf_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rf_writer.sv
// Register-file write front end: merges never-stalling pipeline writeback with a
// FIFO of load results into one write port, and reports pending-write hazards.
// Optional RFW_BYPASS_EN adds fwd1/fwd2 youngest-data bypass outputs.
// DEPTH must be a power of two and at least 2 (pointers wrap by overflow).
module rf_writer #(
  parameter int DEPTH  = 4,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_valid,
  input  logic [REG_W-1:0]         pipe_addr,
  input  logic [DATA_W-1:0]        pipe_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [REG_W-1:0]         ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [REG_W-1:0]         a3,
  output logic [DATA_W-1:0]        wd3,
  output logic                     we3,
  input  logic [REG_W-1:0]         q_a1,
  input  logic [REG_W-1:0]         q_a2,
  output logic                     hit1,
  output logic                     hit2,
`ifdef RFW_BYPASS_EN
  output logic [DATA_W-1:0]        fwd1,
  output logic [DATA_W-1:0]        fwd2,
`endif
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [REG_W-1:0]  r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;

  logic              r_we3;
  logic [REG_W-1:0]  r_a3;
  logic [DATA_W-1:0] r_wd3;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Loads to r0 are handshaken but never stored; a full FIFO refuses even when popping.
  assign w_push   = ld_valid && !w_full && (ld_addr != '0);
  assign w_pop    = !pipe_valid && !w_empty;

  assign ld_ready = !w_full;
  assign pending  = r_count;
  assign we3      = r_we3;
  assign a3       = r_a3;
  assign wd3      = r_wd3;

  // NOTE: storage is deliberately not reset; entry validity comes only from r_count,
  // so a reset that clears the counter and pointers discards every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ld_addr;
      r_fifo_data[r_wr_ptr] <= ld_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pipeline always wins; a pipeline write to r0 still blocks the FIFO that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (pipe_valid) begin
      r_we3 <= (pipe_addr != '0);
      if (pipe_addr != '0) begin
        r_a3  <= pipe_addr;
        r_wd3 <= pipe_data;
      end
    end else if (w_pop) begin
      r_we3 <= 1'b1;
      r_a3  <= r_fifo_addr[r_rd_ptr];
      r_wd3 <= r_fifo_data[r_rd_ptr];
    end else begin
      r_we3 <= 1'b0;
    end
  end

  function automatic logic f_hit(input logic [REG_W-1:0] q);
    logic h;
    h = r_we3 && (r_a3 == q);
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < r_count) && (r_fifo_addr[r_rd_ptr + PTR_W'(i)] == q))
        h = 1'b1;
    end
    return h && (q != '0);
  endfunction

  // NOTE: every always_comb output gets a default before any conditional assignment,
  // otherwise a missed path infers a latch.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    hit1 = f_hit(q_a1);
    hit2 = f_hit(q_a2);
  end

`ifdef RFW_BYPASS_EN
  // Scan oldest to youngest (output register, then FIFO head to tail); last match wins.
  function automatic logic [DATA_W-1:0] f_fwd(input logic [REG_W-1:0] q);
    logic [DATA_W-1:0] d;
    d = '0;
    if (q != '0) begin
      if (r_we3 && (r_a3 == q)) d = r_wd3;
      for (int i = 0; i < DEPTH; i++) begin
        if (((PTR_W+1)'(i) < r_count) && (r_fifo_addr[r_rd_ptr + PTR_W'(i)] == q))
          d = r_fifo_data[r_rd_ptr + PTR_W'(i)];
      end
    end
    return d;
  endfunction

  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    fwd1 = f_fwd(q_a1);
    fwd2 = f_fwd(q_a2);
  end
`endif

endmodule
